// File: rtl/instr_fetch.sv
// Program counter for the 8-bit basic processor's fetch stage.
// Each clock edge the PC holds on Halt, loads Target on Branch, or increments.
module instr_fetch #(
  parameter int              PC_W     = 8,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            CLK,
  input  logic            Init,
  input  logic            Branch,
  input  logic [PC_W-1:0] Target,
  input  logic            Halt,
  output logic [PC_W-1:0] PC
);

  logic [PC_W-1:0] pc_q;
  logic [PC_W-1:0] pc_d;

  // Halt outranks Branch, so a branch that arrives while halted is dropped
  always_comb begin
    pc_d = pc_q;
    if (Halt) begin
      pc_d = pc_q;
    end else if (Branch) begin
      pc_d = Target;
    end else begin
      pc_d = pc_q + PC_W'(1);
    end
  end

  always_ff @(posedge CLK or posedge Init) begin
    if (Init) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign PC = pc_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed scoreboard bench for instr_fetch: expected PC values are queued
// as stimulus is applied and checked against the DUT after each edge.
module tb_instr_fetch;

  localparam int PC_W = 8;

  logic            CLK;
  logic            Init;
  logic            Branch;
  logic [PC_W-1:0] Target;
  logic            Halt;
  logic [PC_W-1:0] PC;

  int errors = 0;
  int checks = 0;
  logic [PC_W-1:0] expQ[$];

  instr_fetch #(.PC_W(PC_W), .RESET_PC(8'd0)) dut (
    .CLK    (CLK),
    .Init   (Init),
    .Branch (Branch),
    .Target (Target),
    .Halt   (Halt),
    .PC     (PC)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag);
    logic [PC_W-1:0] exp;
    checks++;
    if (expQ.size() == 0) begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=<empty scoreboard>", tag, PC);
    end else begin
      exp = expQ.pop_front();
      assert (PC === exp) else begin
        errors++;
        $error("[TB] FAIL %s observed=%0d expected=%0d", tag, PC, exp);
      end
    end
  endtask

  task automatic applyStimulus(input logic init, input logic branch,
                               input logic [PC_W-1:0] target, input logic halt,
                               input logic [PC_W-1:0] exp, input string tag);
    @(negedge CLK);
    Init   = init;
    Branch = branch;
    Target = target;
    Halt   = halt;
    expQ.push_back(exp);
    @(posedge CLK);
    #1;
    checkOutput(tag);
  endtask

  initial begin
    Init   = 1'b0;
    Branch = 1'b0;
    Target = '0;
    Halt   = 1'b0;

    // Reset: async clear then hold across edges, then count up
    #1 Init = 1'b1;
    #1;
    expQ.push_back(8'd0);
    checkOutput("reset_async");
    applyStimulus(1, 0, 8'd0, 0, 8'd0, "reset_edge1");
    applyStimulus(1, 1, 8'd77, 0, 8'd0, "reset_ignores_branch");
    applyStimulus(0, 0, 8'd0, 0, 8'd1, "post_reset_inc1");
    applyStimulus(0, 0, 8'd0, 0, 8'd2, "post_reset_inc2");

    // Branch held for two edges; Target changing after the edge must not matter
    applyStimulus(0, 1, 8'd20, 0, 8'd20, "branch_edge1");
    #2 Target = 8'd77;
    #1;
    expQ.push_back(8'd20);
    checkOutput("target_between_edges");
    applyStimulus(0, 1, 8'd20, 0, 8'd20, "branch_edge2");
    applyStimulus(0, 0, 8'd20, 0, 8'd21, "after_branch_inc1");
    applyStimulus(0, 0, 8'd20, 0, 8'd22, "after_branch_inc2");

    // Branch follows the current Target on each edge
    applyStimulus(0, 1, 8'd50, 0, 8'd50, "branch_follow_a");
    applyStimulus(0, 1, 8'd22, 0, 8'd22, "branch_follow_b");

    // Halt freezes PC, then resumes
    for (int i = 0; i < 5; i++) begin
      applyStimulus(0, 0, 8'd0, 1, 8'd22, "halt_hold");
    end
    applyStimulus(0, 0, 8'd0, 0, 8'd23, "halt_release");

    // Halt beats Branch, and the branch is not remembered
    applyStimulus(0, 1, 8'd100, 1, 8'd23, "halt_over_branch1");
    applyStimulus(0, 1, 8'd100, 1, 8'd23, "halt_over_branch2");
    applyStimulus(0, 0, 8'd100, 0, 8'd24, "priority_release");
    applyStimulus(0, 0, 8'd100, 0, 8'd25, "priority_no_late_branch");

    // Modulo wrap
    applyStimulus(0, 1, 8'd255, 0, 8'd255, "wrap_branch");
    applyStimulus(0, 0, 8'd0, 0, 8'd0, "wrap_zero");
    applyStimulus(0, 0, 8'd0, 0, 8'd1, "wrap_one");

    // Async reset mid-run while halted and branching
    applyStimulus(0, 1, 8'd40, 0, 8'd40, "goto_40");
    @(negedge CLK);
    Halt   = 1'b1;
    Branch = 1'b1;
    Target = 8'd99;
    #2 Init = 1'b1;
    #1;
    expQ.push_back(8'd0);
    checkOutput("async_init_midcycle");
    applyStimulus(1, 1, 8'd99, 1, 8'd0, "init_with_halt_edge");
    applyStimulus(0, 0, 8'd99, 0, 8'd1, "after_midrun_reset");
    applyStimulus(0, 0, 8'd99, 0, 8'd2, "after_midrun_reset2");

    if (expQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_drain observed=%0d expected=0", expQ.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
